// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the register-file access master.
package regfile_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_RMW_ADD = 2'd2,
    OP_SWAP    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/regfile_access_master.sv
// Single-command register-file master: READ, WRITE, RMW_ADD and SWAP with a
// valid/ready command port and a valid/ready response port.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// FETCH  | read data valid for the latched address; WRITE strobes here
// UPDATE | RMW_ADD/SWAP write strobe
// RESP   | rsp_valid high until rsp_ready
module regfile_access_master
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_read_address,
  input  logic [DATA_W-1:0] rf_read_data
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d      = op_e'(cmd_op);
          data_d    = cmd_data;
          rd_addr_d = cmd_addr;
          state_d   = ST_FETCH;
          // WRITE strobes in the FETCH cycle, so the registered strobe is armed on accept
          if (op_e'(cmd_op) == OP_WRITE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_data;
          end
        end
      end
      ST_FETCH: begin
        unique case (op_q)
          OP_READ: begin
            rsp_data_d  = rf_read_data;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
          OP_WRITE: begin
            rsp_data_d  = data_q;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
          OP_RMW_ADD: begin
            rsp_data_d = rf_read_data;
            wr_en_d    = 1'b1;
            wr_addr_d  = rd_addr_q;
            wr_data_d  = rf_read_data + data_q;
            state_d    = ST_UPDATE;
          end
          OP_SWAP: begin
            rsp_data_d = rf_read_data;
            wr_en_d    = 1'b1;
            wr_addr_d  = rd_addr_q;
            wr_data_d  = data_q;
            state_d    = ST_UPDATE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_UPDATE: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      data_q      <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rf_read_address  = rd_addr_q;
  assign rf_write_address = wr_addr_q;
  assign rf_write_data    = wr_data_q;
  assign rf_write_en      = wr_en_q;

endmodule

// File: tb/tb_regfile_access_master.sv
// Directed plus random bench for regfile_access_master against a 4x8 register
// file and an array-based model of the expected register contents.
module tb_regfile_access_master;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rf_write_address;
  logic [7:0] rf_write_data;
  logic       rf_write_en;
  logic [1:0] rf_read_address;
  logic [7:0] rf_read_data;

  logic [7:0] rf     [4];
  logic [7:0] ref_rf [4];
  int n_assert = 0;
  int n_fail   = 0;
  int wr_pulses = 0;

  regfile_access_master #(.ADDR_W(2), .DATA_W(8)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_addr         (cmd_addr),
    .cmd_data         (cmd_data),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .rf_write_en      (rf_write_en),
    .rf_read_address  (rf_read_address),
    .rf_read_data     (rf_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign rf_read_data = rf[rf_read_address];

  always @(posedge clock) begin
    if (rf_write_en === 1'b1) rf[rf_write_address] <= rf_write_data;
  end

  always @(negedge clock) begin
    if (rf_write_en === 1'b1) wr_pulses <= wr_pulses + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called away from the rising edge with the DUT idle; returns at a falling edge.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d,
                        input int hold);
    logic [7:0] exp_rsp;
    logic [7:0] exp_wd;
    logic       writes;
    int         p0;
    exp_rsp = ref_rf[a];
    exp_wd  = ref_rf[a];
    writes  = 1'b1;
    case (op)
      2'd0: writes = 1'b0;
      2'd1: begin exp_rsp = d; exp_wd = d; end
      2'd2: exp_wd = ref_rf[a] + d;
      default: exp_wd = d;
    endcase
    p0 = wr_pulses;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    rsp_ready = (hold == 0);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 2'($urandom); cmd_data = 8'($urandom);
    @(negedge clock);
    chk("fetch_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("fetch_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("fetch_rd_addr", {30'd0, rf_read_address}, {30'd0, a});
    chk("fetch_wr_en", {31'd0, rf_write_en}, {31'd0, (op == 2'd1)});
    if (op == 2'd1) begin
      chk("write_addr", {30'd0, rf_write_address}, {30'd0, a});
      chk("write_data", {24'd0, rf_write_data}, {24'd0, exp_wd});
    end
    if (op >= 2'd2) begin
      @(negedge clock);
      chk("update_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("update_wr_en", {31'd0, rf_write_en}, 32'd1);
      chk("update_addr", {30'd0, rf_write_address}, {30'd0, a});
      chk("update_data", {24'd0, rf_write_data}, {24'd0, exp_wd});
    end
    @(negedge clock);
    chk("resp_latency", {31'd0, rsp_valid}, 32'd1);
    chk("resp_data", {24'd0, rsp_data}, {24'd0, exp_rsp});
    chk("resp_wr_en", {31'd0, rf_write_en}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      cmd_op = 2'($urandom); cmd_addr = 2'($urandom); cmd_data = 8'($urandom);
      @(negedge clock);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp});
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_wr_en", {31'd0, rf_write_en}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    @(negedge clock);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    if (writes) ref_rf[a] = exp_wd;
    chk("rf_contents", {24'd0, rf[a]}, {24'd0, ref_rf[a]});
    chk("wr_pulse_count", wr_pulses - p0, {31'd0, writes});
  endtask

  initial begin
    int p_rst;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 2'd0;
    cmd_data  = 8'd0;
    rsp_ready = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, rf_write_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_wr_addr", {30'd0, rf_write_address}, 32'd0);
    chk("rst_wr_data", {24'd0, rf_write_data}, 32'd0);
    chk("rst_rd_addr", {30'd0, rf_read_address}, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("rst_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Contents are unknown after reset, so every address is written first.
    for (int i = 0; i < 4; i++) do_cmd(2'd1, 2'(i), 8'($urandom), 0);

    do_cmd(2'd1, 2'd2, 8'h5A, 0);
    do_cmd(2'd0, 2'd2, 8'h00, 0);
    chk("raw_read_value", {24'd0, rsp_data}, 32'h5A);

    do_cmd(2'd1, 2'd1, 8'hF0, 0);
    do_cmd(2'd2, 2'd1, 8'h20, 0);
    chk("rmw_carry_dropped", {24'd0, rf[1]}, 32'h10);

    do_cmd(2'd1, 2'd3, 8'h11, 1);
    do_cmd(2'd3, 2'd3, 8'hAB, 0);
    do_cmd(2'd0, 2'd3, 8'h00, 0);
    chk("swap_read_back", {24'd0, rf[3]}, 32'hAB);

    do_cmd(2'd0, 2'd2, 8'h00, 5);

    for (int i = 0; i < 24; i++)
      do_cmd(2'($urandom_range(0, 3)), 2'($urandom), 8'($urandom), $urandom_range(0, 3));

    // Reset during UPDATE of an RMW_ADD must abandon it without a write.
    p_rst = wr_pulses;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 2'd1; cmd_data = 8'h33; rsp_ready = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    @(posedge clock); #1;
    chk("pre_rst_update_wr_en", {31'd0, rf_write_en}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, rf_write_en}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("mid_rst_wr_addr", {30'd0, rf_write_address}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    chk("mid_rst_release_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    chk("mid_rst_reg_unchanged", {24'd0, rf[1]}, {24'd0, ref_rf[1]});
    chk("mid_rst_no_strobe", wr_pulses - p_rst, 32'd0);
    chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;
    do_cmd(2'd0, 2'd1, 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
